// File: rtl/vga_pixel_out.sv
//------------------------------------------------------------------------------
// vga_pixel_out
//
// Terminal stage of the VGA pipeline. Generates 640x480@60 raster timing on
// the pixel clock, publishes the current raster position to every drawing
// object, and drives the DAC pins.
//
// Pixel (x,y) travels through the design as follows:
//   cycle t           : pixelX/pixelY = (x,y) are issued to the drawing objects
//   cycle t+PIPE_DELAY: the matching colour returns on RGBIn
//   edge  t+PIPE_DELAY+1: the output register loads the colour and the
//                         delayed sync/blank flags, so every pin changes together
//
// The sync/blank flags go through a PIPE_DELAY-deep shift register so that
// they line up with the colour returning from upstream.
//
// Ports:
//   clk          in   pixel clock (25 MHz)
//   resetN       in   asynchronous, active-low reset
//   RGBIn        in   [7:0] colour from the objects mux, {R[2:0],G[2:0],B[1:0]}
//   pixelX       out  [10:0] current horizontal counter
//   pixelY       out  [10:0] current vertical counter
//   startOfFrame out  one-clock pulse in the cycle the counters return to (0,0)
//   vgaR/G/B     out  [3:0] colour to the DAC, forced to 0 outside the active area
//   vgaHS        out  horizontal sync, active low
//   vgaVS        out  vertical sync, active low
//   vgaBlankN    out  high while an active pixel is on the pins
//
// PIPE_DELAY is legal in 1..4. Counters are 11 bits wide, so horizontal and
// vertical totals must not exceed 2047.
//------------------------------------------------------------------------------
module vga_pixel_out #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  RGBIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic [3:0]  vgaR,
    output logic [3:0]  vgaG,
    output logic [3:0]  vgaB,
    output logic        vgaHS,
    output logic        vgaVS,
    output logic        vgaBlankN
);

    //--------------------------------------------------------------------------
    // Raster geometry, pre-cast to counter width so all compares are 11 bits
    //--------------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_END    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_END    = 11'(V_ACTIVE);
    localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    // Timing flags carried alongside the pixel. Syncs are active-high here;
    // the pin polarity inversion happens only in the output register.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } flags_t;

    localparam flags_t FLAGS_IDLE = '{active: 1'b0, hs: 1'b0, vs: 1'b0};

    //--------------------------------------------------------------------------
    // Raster counters
    //--------------------------------------------------------------------------
    logic [10:0] h_count;
    logic [10:0] v_count;
    logic        h_at_end;
    logic        v_at_end;

    assign h_at_end = (h_count == H_LAST);
    assign v_at_end = (v_count == V_LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge regardless of the
    // order in which the simulator evaluates the always blocks.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_at_end) begin
            h_count <= '0;
            // The line advances on the same edge the horizontal counter wraps.
            if (v_at_end) begin
                v_count <= '0;
            end else begin
                v_count <= v_count + 11'd1;
            end
        end else begin
            h_count <= h_count + 11'd1;
        end
    end

    // Drawing objects see the counters directly, with no extra register.
    assign pixelX = h_count;
    assign pixelY = v_count;

    // Registered so the pulse lands in the cycle the counters read (0,0).
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            startOfFrame <= 1'b0;
        end else begin
            startOfFrame <= h_at_end && v_at_end;
        end
    end

    //--------------------------------------------------------------------------
    // Raw timing decode for the pixel currently being issued
    //--------------------------------------------------------------------------
    flags_t raw_flags;

    // NOTE: every output of a combinational block gets a default value first,
    // so no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        raw_flags        = FLAGS_IDLE;
        raw_flags.active = (h_count < H_ACT_END) && (v_count < V_ACT_END);
        raw_flags.hs     = (h_count >= H_SYNC_START) && (h_count < H_SYNC_END);
        raw_flags.vs     = (v_count >= V_SYNC_START) && (v_count < V_SYNC_END);
    end

    //--------------------------------------------------------------------------
    // Flag delay line: matches the upstream colour latency
    //--------------------------------------------------------------------------
    flags_t dly_q [PIPE_DELAY];
    flags_t dly_tail;

    // NOTE: this storage array is reset on purpose: its last stage feeds the
    // pins, and a reset must take effect immediately with syncs deasserted and
    // blank active, leaving no stale pulse to drain out after release.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < PIPE_DELAY; i++) begin
                dly_q[i] <= FLAGS_IDLE;
            end
        end else begin
            dly_q[0] <= raw_flags;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign dly_tail = dly_q[PIPE_DELAY-1];

    //--------------------------------------------------------------------------
    // Colour expansion 3:3:2 -> 4:4:4
    //--------------------------------------------------------------------------
    // Replicating the top bits stretches each channel across the full 4-bit
    // range: a saturated input drives 4'hF, and black stays black.
    logic [2:0] in_r;
    logic [2:0] in_g;
    logic [1:0] in_b;
    logic [3:0] exp_r;
    logic [3:0] exp_g;
    logic [3:0] exp_b;

    assign in_r  = RGBIn[7:5];
    assign in_g  = RGBIn[4:2];
    assign in_b  = RGBIn[1:0];
    assign exp_r = {in_r, in_r[2]};
    assign exp_g = {in_g, in_g[2]};
    assign exp_b = {in_b, in_b};

    //--------------------------------------------------------------------------
    // Output register: colour and delayed flags change on the same edge
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            vgaR      <= '0;
            vgaG      <= '0;
            vgaB      <= '0;
            vgaHS     <= 1'b1;
            vgaVS     <= 1'b1;
            vgaBlankN <= 1'b0;
        end else begin
            vgaBlankN <= dly_tail.active;
            vgaHS     <= ~dly_tail.hs;
            vgaVS     <= ~dly_tail.vs;
            // Outside the visible area the DAC must see black, whatever the
            // objects mux happens to return.
            if (dly_tail.active) begin
                vgaR <= exp_r;
                vgaG <= exp_g;
                vgaB <= exp_b;
            end else begin
                vgaR <= '0;
                vgaG <= '0;
                vgaB <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_pixel_out.sv
//------------------------------------------------------------------------------
// tb_vga_pixel_out
//
// Two instances run side by side from one clock and reset: one with
// PIPE_DELAY=1 and one with PIPE_DELAY=3. Each has its own upstream model
// that returns a colour for pixelX/pixelY exactly PIPE_DELAY clocks later.
// Horizontal timing is the standard 800-clock line; the vertical geometry is
// shrunk so that several complete frames fit in a short run.
//
// Reference model: the cycle count n since reset release gives the raster
// position by division, and the pins at cycle n show pixel n-PIPE_DELAY-1.
//------------------------------------------------------------------------------
module tb_vga_pixel_out;

    localparam int HA    = 640;
    localparam int HF    = 16;
    localparam int HSY   = 96;
    localparam int HB    = 48;
    localparam int HT    = HA + HF + HSY + HB;
    localparam int VA    = 12;
    localparam int VF    = 2;
    localparam int VSY   = 2;
    localparam int VB    = 2;
    localparam int VT    = VA + VF + VSY + VB;
    localparam int FRAME = HT * VT;
    localparam int MAXN  = 32768;

    logic clk = 1'b0;
    logic resetN;
    always #20 clk = ~clk;

    logic [7:0]  rgb1, rgb3;
    logic [10:0] px1, py1, px3, py3;
    logic        sof1, sof3;
    logic [3:0]  r1, g1, b1, r3, g3, b3;
    logic        hs1, vs1, bl1, hs3, vs3, bl3;

    vga_pixel_out #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .PIPE_DELAY(1)
    ) dut1 (
        .clk(clk), .resetN(resetN), .RGBIn(rgb1),
        .pixelX(px1), .pixelY(py1), .startOfFrame(sof1),
        .vgaR(r1), .vgaG(g1), .vgaB(b1),
        .vgaHS(hs1), .vgaVS(vs1), .vgaBlankN(bl1)
    );

    vga_pixel_out #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .PIPE_DELAY(3)
    ) dut3 (
        .clk(clk), .resetN(resetN), .RGBIn(rgb3),
        .pixelX(px3), .pixelY(py3), .startOfFrame(sof3),
        .vgaR(r3), .vgaG(g3), .vgaB(b3),
        .vgaHS(hs3), .vgaVS(vs3), .vgaBlankN(bl3)
    );

    typedef enum int {MODE_RAND, MODE_X, MODE_CONST} mode_e;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n;
    mode_e       mode;
    logic [7:0]  const_col;
    logic [7:0]  lut [256];
    logic [7:0]  col_hist [MAXN];
    mode_e       mode_hist [MAXN];
    logic [7:0]  q1 [$];
    logic [7:0]  q3 [$];

    // Per-instance observation state (index 0: delay 1, index 1: delay 3)
    int          hs_run  [2];
    int          act_run [2];
    int          vs_low  [2];
    logic        prev_hs [2];
    logic        prev_bl [2];
    logic [7:0]  prev_dec[2];
    mode_e       prev_mode[2];
    int          sof_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    // Colour the upstream objects would produce for a pixel.
    function automatic logic [7:0] colour_of(input int x, input int y);
        logic [7:0] idx;
        logic [7:0] xb;
        idx = 8'((x * 3 + y * 5) % 256);
        xb  = 8'(x % 256);
        case (mode)
            MODE_RAND: return lut[idx];
            MODE_X:    return xb;
            default:   return const_col;
        endcase
    endfunction

    // Expected {hs, vs, blankN, R, G, B} at cycle nn for an instance of delay pd.
    function automatic logic [14:0] exp_pins(input int pd, input int nn);
        int m, x, y, rc, gc, bc;
        logic act, hs, vs;
        logic [7:0] c;
        if (nn < pd + 1) return 15'h6000;
        m   = nn - pd - 1;
        x   = m % HT;
        y   = (m / HT) % VT;
        act = (x < HA) && (y < VA);
        hs  = !((x >= HA + HF) && (x < HA + HF + HSY));
        vs  = !((y >= VA + VF) && (y < VA + VF + VSY));
        c   = col_hist[m];
        rc  = 0; gc = 0; bc = 0;
        if (act) begin
            rc = int'(c[7:5]) * 2 + int'(c[7:5]) / 4;
            gc = int'(c[4:2]) * 2 + int'(c[4:2]) / 4;
            bc = int'(c[1:0]) * 5;
        end
        return {hs, vs, act, 4'(rc), 4'(gc), 4'(bc)};
    endfunction

    task automatic clear_tracking();
        for (int i = 0; i < 2; i++) begin
            hs_run[i]   = 0;
            act_run[i]  = 0;
            vs_low[i]   = 0;
            prev_hs[i]  = 1'b1;
            prev_bl[i]  = 1'b0;
            prev_dec[i] = 8'h00;
            prev_mode[i] = MODE_RAND;
        end
        sof_cnt = 0;
    endtask

    task automatic check_dut(input int id, input int pd, input logic hs, input logic vs,
                             input logic bl, input logic [3:0] r, input logic [3:0] g,
                             input logic [3:0] b);
        int m;
        logic [7:0] dec;
        m   = n - pd - 1;
        dec = {r[3:1], g[3:1], b[1:0]};
        chk($sformatf("pins_pd%0d", pd), {17'h0, hs, vs, bl, r, g, b}, {17'h0, exp_pins(pd, n)});
        if (!hs) begin
            hs_run[id]++;
        end else begin
            if (!prev_hs[id]) chk($sformatf("hs_width_pd%0d", pd), hs_run[id], HSY);
            hs_run[id] = 0;
        end
        if (!vs) vs_low[id]++;
        if (bl) begin
            if (!prev_bl[id] && m >= 0 && mode_hist[m] == MODE_X)
                chk($sformatf("first_x_pd%0d", pd), dec, 8'h00);
            act_run[id]++;
        end else begin
            if (prev_bl[id]) begin
                chk($sformatf("active_run_pd%0d", pd), act_run[id], HA);
                if (prev_mode[id] == MODE_X)
                    chk($sformatf("last_x_pd%0d", pd), prev_dec[id], 8'h7F);
            end
            act_run[id] = 0;
        end
        prev_hs[id]   = hs;
        prev_bl[id]   = bl;
        prev_dec[id]  = dec;
        prev_mode[id] = (m >= 0) ? mode_hist[m] : MODE_RAND;
    endtask

    // Called once per cycle, away from the active edge.
    task automatic sample();
        int x, y;
        x = n % HT;
        y = (n / HT) % VT;
        col_hist[n]  = colour_of(x, y);
        mode_hist[n] = mode;
        chk("pixelX_pd1", px1, x);
        chk("pixelY_pd1", py1, y);
        chk("pixelX_pd3", px3, x);
        chk("pixelY_pd3", py3, y);
        chk("sof_pd1", sof1, (n > 0) && (n % FRAME == 0));
        chk("sof_pd3", sof3, (n > 0) && (n % FRAME == 0));
        if (sof1) sof_cnt++;
        check_dut(0, 1, hs1, vs1, bl1, r1, g1, b1);
        check_dut(1, 3, hs3, vs3, bl3, r3, g3, b3);
        // Upstream: return the colour for the coordinates issued PIPE_DELAY clocks ago.
        q1.push_back(colour_of(int'(px1), int'(py1)));
        q3.push_back(colour_of(int'(px3), int'(py3)));
        rgb1 = (q1.size() > 1) ? q1.pop_front() : 8'h00;
        rgb3 = (q3.size() > 3) ? q3.pop_front() : 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        if (n >= MAXN) begin
            $display("FAIL cycle_budget: observed %0d expected below %0d", n, MAXN);
            $fatal(1, "cycle budget exceeded");
        end
        @(negedge clk);
        sample();
    endtask

    task automatic check_reset_values();
        chk("rst_pins_pd1", {17'h0, hs1, vs1, bl1, r1, g1, b1}, 32'h6000);
        chk("rst_pins_pd3", {17'h0, hs3, vs3, bl3, r3, g3, b3}, 32'h6000);
        chk("rst_xy_pd1", {px1, py1}, 0);
        chk("rst_xy_pd3", {px3, py3}, 0);
        chk("rst_sof", {sof1, sof3}, 0);
    endtask

    // Asserts reset (asynchronously), holds it for `cycles` clocks, releases
    // it on a falling edge and samples the first post-release cycle.
    task automatic apply_reset(input int cycles);
        resetN = 1'b0;
        #1;
        check_reset_values();
        repeat (cycles) begin
            @(negedge clk);
            check_reset_values();
        end
        resetN = 1'b1;
        n = 0;
        q1.delete();
        q3.delete();
        clear_tracking();
        sample();
    endtask

    initial begin
        resetN    = 1'b1;
        rgb1      = 8'h00;
        rgb3      = 8'h00;
        n         = 0;
        mode      = MODE_RAND;
        const_col = 8'h00;
        for (int i = 0; i < 256; i++) lut[i] = 8'($urandom);
        clear_tracking();
        #5;
        apply_reset(3);

        // Horizontal counting and wrap over the first line
        repeat (HT) tick();
        chk("wrap_x", px1, 0);
        chk("wrap_y", py1, 1);
        chk("no_sof_line0", sof_cnt, 0);

        // Saturated colour in the active region, then during horizontal blank
        mode = MODE_CONST;
        const_col = 8'hFF;
        while (n < 2 * HT + 102) tick();
        chk("ff_r", r1, 4'hF);
        chk("ff_g", g1, 4'hF);
        chk("ff_b", b1, 4'hF);
        while (n < 2 * HT + 700) tick();
        chk("blank_r", r1, 4'h0);
        chk("blank_g", g1, 4'h0);
        chk("blank_b", b1, 4'h0);
        chk("blank_n", bl1, 1'b0);

        // Bit pattern 101_010_01 through both delays
        const_col = 8'b101_010_01;
        while (n < 3 * HT + 102) tick();
        chk("pat_r_pd1", r1, 4'b1011);
        chk("pat_g_pd1", g1, 4'b0100);
        chk("pat_b_pd1", b1, 4'b0101);
        while (n < 3 * HT + 104) tick();
        chk("pat_r_pd3", r3, 4'b1011);
        chk("pat_g_pd3", g3, 4'b0100);
        chk("pat_b_pd3", b3, 4'b0101);

        // Alignment: colour encodes pixelX, checked at each line's first/last pixel
        mode = MODE_X;
        while (n < 10 * HT) tick();

        // Rest of the frame with random colour; frame-level sync and SOF counts
        mode = MODE_RAND;
        while (n < FRAME + 10) tick();
        chk("vs_low_pd1", vs_low[0], VSY * HT);
        chk("vs_low_pd3", vs_low[1], VSY * HT);
        chk("sof_once", sof_cnt, 1);

        // Reset mid-frame at (300,10) for 5 clocks
        while (n < FRAME + 10 * HT + 300) tick();
        chk("pre_rst_x", px1, 300);
        chk("pre_rst_y", py1, 10);
        apply_reset(5);
        repeat (3) tick();
        chk("post_rst_x", px1, 3);
        chk("post_rst_y", py1, 0);
        while (n < FRAME + 10) tick();
        chk("post_vs_low_pd1", vs_low[0], VSY * HT);
        chk("post_vs_low_pd3", vs_low[1], VSY * HT);
        chk("post_sof_once", sof_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
